// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: default vectors,
// instruction field positions and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (exc > jump > branch > pc+4) with target alignment.
// Ports: i_pc, redirect requests/targets in; o_next_pc, o_redirect, o_misaligned out.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] i_pc,
  input  logic        i_exc_redirect,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_next_pc,
  output logic        o_redirect,
  output logic        o_misaligned
);

  logic [31:0] raw;

  always_comb begin
    raw = i_pc + 32'd4;
    if (i_exc_redirect) begin
      raw = EXC_VECTOR;
    end else if (i_jump) begin
      raw = i_jump_target;
    end else if (i_branch_taken) begin
      raw = i_branch_target;
    end
  end

  assign o_redirect   = i_exc_redirect | i_jump | i_branch_taken;
  assign o_next_pc    = {raw[31:2], 2'b00};
  assign o_misaligned = o_redirect & (raw[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, issues imem req/ack, presents word to decode.
// Ports: i_clk/i_rst, stall and redirects in; imem req/addr/ack/data; o_valid, instr, pc, fields.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_exc_redirect,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm16,
  output logic        o_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  opc_q, opc_d;
  logic         kill_q, kill_d;
  logic         mis_q, mis_d;

  logic [31:0]  sel_pc;
  logic         sel_redir;
  logic         sel_mis;

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_sel (
    .i_pc           (pc_q),
    .i_exc_redirect (i_exc_redirect),
    .i_jump         (i_jump),
    .i_jump_target  (i_jump_target),
    .i_branch_taken (i_branch_taken),
    .i_branch_target(i_branch_target),
    .o_next_pc      (sel_pc),
    .o_redirect     (sel_redir),
    .o_misaligned   (sel_mis)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= 32'h0;
      opc_q   <= RESET_PC;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  // addr_q holds the address of the outstanding request; it only moves
  // when a new request starts, so a redirect cannot disturb an in-flight one.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    kill_d  = kill_q;
    mis_d   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (sel_redir) begin
          pc_d  = sel_pc;
          mis_d = sel_mis;
        end
        if (i_imem_ack) begin
          if (kill_q || sel_redir) begin
            kill_d = 1'b0;
            addr_d = pc_d;
          end else begin
            instr_d = i_imem_data;
            opc_d   = addr_q;
            state_d = ISSUE;
          end
        end else if (sel_redir) begin
          kill_d = 1'b1;
        end
      end
      ISSUE: begin
        if (!i_stall) begin
          pc_d    = sel_pc;
          addr_d  = sel_pc;
          mis_d   = sel_mis;
          state_d = FETCH;
        end
      end
    endcase
  end

  assign o_imem_req   = (state_q == FETCH);
  assign o_imem_addr  = addr_q;
  assign o_valid      = (state_q == ISSUE);
  assign o_instr      = instr_q;
  assign o_pc         = opc_q;
  assign o_pc_plus4   = opc_q + 32'd4;
  assign o_rs         = instr_q[RS_LSB +: REG_W];
  assign o_rt         = instr_q[RT_LSB +: REG_W];
  assign o_rd         = instr_q[RD_LSB +: REG_W];
  assign o_imm16      = instr_q[IMM_LSB +: IMM_W];
  assign o_misaligned = mis_q;

endmodule
